// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine.
package multdiv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned MULT_STEPS = 16;
  localparam int unsigned DIV_STEPS  = 32;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int unsigned RSTATUS_MULT = 4;
  localparam int unsigned RSTATUS_DIV  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_M1   = 3'd3,
    BOOTH_M2   = 3'd4
  } booth_sel_e;

  // Two's complement magnitude; 0x80000000 maps to 2^31 read as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? (XLEN'(0) - x) : x;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth digit recoder: 3-bit window -> sign-extended addend.
module booth_recoder
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] addend_c
);

  booth_sel_e         sel;
  logic [WIDTH+1:0]   ext;

  // Decode the overlapping bit window into a signed multiple of the multiplicand.
  always_comb begin
    sel = BOOTH_ZERO;
    unique case (digit)
      3'b001, 3'b010: sel = BOOTH_P1;
      3'b011:         sel = BOOTH_P2;
      3'b100:         sel = BOOTH_M2;
      3'b101, 3'b110: sel = BOOTH_M1;
      default:        sel = BOOTH_ZERO;
    endcase
  end

  // Produce the addend at accumulator width (two guard bits cover +/-2M).
  always_comb begin
    ext      = {{2{mcand[WIDTH-1]}}, mcand};
    addend_c = '0;
    unique case (sel)
      BOOTH_P1: addend_c = ext;
      BOOTH_P2: addend_c = {ext[WIDTH:0], 1'b0};
      BOOTH_M1: addend_c = (WIDTH+2)'(0) - ext;
      BOOTH_M2: addend_c = (WIDTH+2)'(0) - {ext[WIDTH:0], 1'b0};
      default:  addend_c = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) engine.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] ir_in,
  output logic             busy,
  output logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic [WIDTH-1:0] ir_out
);

  localparam int unsigned PW = 2*WIDTH + 1;   // {acc, multiplier, guard}
  localparam int unsigned RW = WIDTH + 2;     // signed partial remainder

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [PW-1:0]      prod_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [RW-1:0]      rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic               neg_q, dzero_q, dovf_q;
  logic               busy_q, ready_q, exc_q;
  logic [WIDTH-1:0]   result_q, ir_q;

  logic               start_c, mult_last_c, div_last_c;
  logic [WIDTH+1:0]   addend_c, sum_c;
  logic [PW-1:0]      prod_nxt_c;
  logic               mult_ovf_c;
  logic [RW-1:0]      shifted_c, rem_nxt_c;
  logic [WIDTH-1:0]   quo_nxt_c, div_res_c;

  booth_recoder #(.WIDTH(WIDTH)) u_booth (
    .digit    (prod_q[2:0]),
    .mcand    (opnd_q),
    .addend_c (addend_c)
  );

  // Step controls and one-iteration datapath results.
  always_comb begin
    start_c     = ((state_q == IDLE) || (state_q == DONE)) && (ctrl_mult || ctrl_div);
    mult_last_c = (state_q == MULT) && (cnt_q == CNT_W'(MULT_STEPS - 1));
    div_last_c  = (state_q == DIV)  && (cnt_q == CNT_W'(DIV_STEPS - 1));

    sum_c      = {{2{prod_q[PW-1]}}, prod_q[PW-1:WIDTH+1]} + addend_c;
    prod_nxt_c = {sum_c, prod_q[WIDTH:2]};
    mult_ovf_c = prod_nxt_c[PW-1:WIDTH+1] != {WIDTH{prod_nxt_c[WIDTH]}};

    shifted_c = {rem_q[RW-2:0], quo_q[WIDTH-1]};
    rem_nxt_c = rem_q[RW-1] ? (shifted_c + {2'b00, opnd_q})
                            : (shifted_c - {2'b00, opnd_q});
    quo_nxt_c = {quo_q[WIDTH-2:0], ~rem_nxt_c[RW-1]};
    div_res_c = dzero_q ? '0 : (neg_q ? (WIDTH'(0) - quo_nxt_c) : quo_nxt_c);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; multiply wins when both strobes are present.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (ctrl_mult)     state_d = MULT;
        else if (ctrl_div) state_d = DIV;
        else               state_d = IDLE;
      end
      MULT:    if (mult_last_c) state_d = DONE;
      DIV:     if (div_last_c)  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      prod_q   <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      neg_q    <= 1'b0;
      dzero_q  <= 1'b0;
      dovf_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      exc_q    <= 1'b0;
      result_q <= '0;
      ir_q     <= '0;
    end else begin
      busy_q  <= (state_d == MULT) || (state_d == DIV);
      ready_q <= (state_d == DONE);
      if (start_c) begin
        cnt_q <= '0;
        ir_q  <= ir_in;
        if (ctrl_mult) begin
          opnd_q <= operand_a;
          prod_q <= {WIDTH'(0), operand_b, 1'b0};
        end else begin
          opnd_q  <= mag(operand_b);
          quo_q   <= mag(operand_a);
          rem_q   <= '0;
          neg_q   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
          dzero_q <= (operand_b == '0);
          dovf_q  <= (operand_a == {1'b1, (WIDTH-1)'(0)}) && (operand_b == '1);
        end
      end else if (state_q == MULT) begin
        prod_q <= prod_nxt_c;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (mult_last_c) begin
          result_q <= prod_nxt_c[WIDTH:1];
          exc_q    <= mult_ovf_c;
        end
      end else if (state_q == DIV) begin
        rem_q <= rem_nxt_c;
        quo_q <= quo_nxt_c;
        cnt_q <= cnt_q + CNT_W'(1);
        if (div_last_c) begin
          result_q <= div_res_c;
          exc_q    <= dzero_q | dovf_q;
        end
      end
    end
  end

  assign busy         = busy_q;
  assign result_ready = ready_q;
  assign result       = result_q;
  assign exception    = exc_q;
  assign ir_out       = ir_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed operand vectors, decoupled monitor.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_mult, ctrl_div;
  logic [31:0] operand_a, operand_b, ir_in;
  logic        busy, result_ready, exception;
  logic [31:0] result, ir_out;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [31:0] ir;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .ir_in        (ir_in),
    .busy         (busy),
    .result_ready (result_ready),
    .result       (result),
    .exception    (exception),
    .ir_out       (ir_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset === 1'b1 && result_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got result %h with no pending op (cycle %0d)", result, cyc);
      end else begin
        e = sb.pop_front();
        chk("result",    result,           e.res);
        chk("exception", {31'd0, exception}, {31'd0, e.exc});
        chk("ir_out",    ir_out,           e.ir);
        chk("latency",   cyc,              e.at);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Drive a start at the current negedge; push the expectation once sampled.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ir, input logic [31:0] er, input logic ee,
                       input int unsigned lat);
    exp_t e;
    ctrl_mult = m;
    ctrl_div  = d;
    operand_a = a;
    operand_b = b;
    ir_in     = ir;
    @(posedge clock);
    #1;
    e.res = er; e.exc = ee; e.ir = ir; e.at = cyc + lat;
    sb.push_back(e);
    @(negedge clock);
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h0BAD_F00D;
    ir_in     = 32'h0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clock);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int bcount;
    reset = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0;
    operand_a = '0; operand_b = '0; ir_in = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy",   {31'd0, busy},         32'd0);
    chk("rst_ready",  {31'd0, result_ready}, 32'd0);
    chk("rst_exc",    {31'd0, exception},    32'd0);
    chk("rst_result", result,                32'd0);
    chk("rst_ir",     ir_out,                32'd0);
    reset = 1'b1;

    // Multiplies.
    @(negedge clock); issue(1, 0, 32'd7,        32'hFFFF_FFFD, 32'h01C0_0011, 32'hFFFF_FFEB, 0, 16); wait_idle();
    @(negedge clock); issue(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0240_0022, 32'h0000_0000, 1, 16); wait_idle();
    @(negedge clock); issue(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0280_0033, 32'h0000_0000, 1, 16); wait_idle();

    // Divides.
    @(negedge clock); issue(0, 1, 32'hFFFF_FFF9, 32'd2,        32'h0300_0044, 32'hFFFF_FFFD, 0, 32); wait_idle();
    @(negedge clock); issue(0, 1, 32'd100,       32'd7,        32'h0340_0055, 32'd14,        0, 32); wait_idle();
    @(negedge clock); issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0380_0066, 32'h8000_0000, 1, 32); wait_idle();
    @(negedge clock); issue(0, 1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h03C0_0077, 32'd14,        0, 32); wait_idle();
    @(negedge clock); issue(0, 1, 32'd7,         32'hFFFF_FF9C, 32'h0400_0088, 32'd0,         0, 32); wait_idle();

    // Divide by zero: busy for the whole interval.
    @(negedge clock); issue(0, 1, 32'd5, 32'd0, 32'h0440_0099, 32'd0, 1, 32);
    bcount = 0;
    for (int i = 0; i < 31; i++) begin
      if (busy === 1'b1) bcount++;
      @(negedge clock);
    end
    chk("div0_busy_cycles", 32'(bcount), 32'd31);
    wait_idle();

    // A divide strobe mid-multiply is ignored.
    @(negedge clock); issue(1, 0, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'h0480_00AA, 32'd42, 0, 16);
    repeat (3) @(negedge clock);
    ctrl_div = 1'b1; operand_a = 32'd9; operand_b = 32'd3;
    @(negedge clock);
    ctrl_div = 1'b0;
    wait_idle();
    repeat (40) @(negedge clock);

    // Back-to-back: second multiply started in the DONE cycle.
    @(negedge clock); issue(1, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h04C0_00BB, 32'h8000_0001, 0, 16);
    n = 0;
    while (result_ready !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("b2b_reached_done", {31'd0, result_ready}, 32'd1);
    issue(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0500_00CC, 32'h0, 1, 16);
    wait_idle();

    // Both strobes: multiply wins.
    @(negedge clock); issue(1, 1, 32'd6, 32'd5, 32'h0540_00DD, 32'd30, 0, 16); wait_idle();

    // Asynchronous reset mid-divide discards the operation.
    @(negedge clock); issue(0, 1, 32'd1000, 32'd3, 32'h0580_00EE, 32'd333, 0, 32);
    repeat (8) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy},         32'd0);
    chk("mid_rst_ready",  {31'd0, result_ready}, 32'd0);
    chk("mid_rst_exc",    {31'd0, exception},    32'd0);
    chk("mid_rst_result", result,                32'd0);
    chk("mid_rst_ir",     ir_out,                32'd0);
    sb.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    // Fresh multiply after reset.
    issue(1, 0, 32'd123, 32'hFFFF_FFFE, 32'h05C0_00FF, 32'hFFFF_FF0A, 0, 16); wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed multiply/divide engine that consumes execute-stage operands from the 5-stage pipeline and returns a tagged result for writeback. It accepts a one-cycle start strobe with two 32-bit operands and the issuing instruction word. It computes over multiple cycles while signalling `busy`, so the pipeline can hold fetch/decode. It then presents the result, an exception flag and the carried instruction word for exactly one cycle.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; only 32 is supported.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ctrl_mult` in 1: start multiply; sampled on a rising edge.
- `ctrl_div` in 1: start divide; sampled on a rising edge.
- `operand_a` in 32: multiplicand / dividend (two's complement).
- `operand_b` in 32: multiplier / divisor (two's complement).
- `ir_in` in 32: instruction word captured with the start.
- `busy` out 1: high while an operation is iterating.
- `result_ready` out 1: one-cycle pulse; `result`, `exception` and `ir_out` are valid during it.
- `result` out 32: product low word or quotient.
- `exception` out 1: overflow or divide-by-zero, qualified by `result_ready`.
- `ir_out` out 32: captured `ir_in` (destination register is in bits [26:22]).

## Operation
- FSM states are IDLE, MULT, DIV and DONE.
- **IDLE**
  - `ctrl_mult`=1 → MULT: latch the operands and `ir_in`, clear the step counter.
  - else `ctrl_div`=1 → DIV: same latching.
  - If both are high, multiply wins.
- **MULT**
  - Radix-4 modified Booth, one step per cycle, 16 steps.
  - Uses a 65-bit {acc, multiplier, guard} register.
  - Counter reaching 15 → DONE.
- **DIV**
  - Non-restoring division on magnitudes, one bit per cycle, 32 steps.
  - Quotient sign = sign(a) XOR sign(b); truncate toward zero; the remainder is discarded.
  - Counter reaching 31 → DONE.
- **DONE**
  - `result_ready`=1 for one cycle.
  - A start seen in DONE is accepted (go to MULT/DIV); otherwise → IDLE.
- Starts arriving in MULT or DIV are ignored; no queueing.
- Exceptions:
  - **Multiply:** the 64-bit product is not the sign-extension of its low 32 bits → `exception`=1, `result`=low 32 bits.
  - **Divide, b==0:** `exception`=1, `result`=0. This is detected at start, but the full 32-cycle latency is still taken.
  - **Divide, a=0x80000000, b=-1:** `exception`=1, `result`=0x80000000.
- `ir_out` holds the last captured instruction word; it is not cleared at DONE.

## Timing
- Start is sampled at edge E0.
- `busy` is high from after E0 through the cycle before DONE.
- Latency:
  - **Multiply:** `result_ready` is high in the cycle after E16, so 16 cycles of busy.
  - **Divide:** `result_ready` is high in the cycle after E32.
- `busy` is low during DONE. The consumer's stall must therefore include `result_ready` as well as `busy` in the start cycle.
- Back-to-back: a start in the DONE cycle gives the next `result_ready` 16/32 cycles later, with no idle gap.
- Reset (`reset`=0, at any time, including mid-operation):
  - FSM → IDLE, counter=0.
  - `busy`=0, `result_ready`=0, `exception`=0, `result`=0, `ir_out`=0.
  - Any in-flight operation is discarded.
- All outputs are registered; none is combinational from the inputs.

## Structure
- Shared package `multdiv_pkg`:
  - state enum {IDLE, MULT, DIV, DONE}
  - `MULT_STEPS`=16, `DIV_STEPS`=32
  - `ALU_MULT`=5'b00110, `ALU_DIV`=5'b00111
  - exception codes `RSTATUS_MULT`=4, `RSTATUS_DIV`=5, used by the consumer to write $r30.
- Sub-module `booth_recoder`: combinational 3-bit Booth digit → {0, +M, +2M, −M, −2M} addend select. Everything else lives in `multdiv_unit`.

## Test plan
- Multiply: `ctrl_mult`, a=7, b=−3 → `result_ready` exactly 16 cycles after start, `result`=0xFFFFFFEB, `exception`=0, `ir_out`=`ir_in`.
- Multiply overflow: a=0x00010000, b=0x00010000 → `result`=0, `exception`=1. Also check a=0x7FFFFFFF, b=−1 → 0x80000001, `exception`=0.
- Divide:
  - a=−7, b=2 → `result`=0xFFFFFFFD, ready at 32 cycles.
  - a=100, b=7 → 14.
  - a=0x80000000, b=−1 → 0x80000000, `exception`=1.
- Divide by zero: a=5, b=0 → `result`=0, `exception`=1 at 32 cycles; `busy` is high for the whole interval.
- Start handling:
  - Pulse `ctrl_div` at cycle 5 of a multiply → ignored; the multiply result is unchanged.
  - Issue a new `ctrl_mult` in the DONE cycle → second result 16 cycles later.
  - Both strobes together → multiply.
- Reset: assert `reset`=0 at cycle 10 of a divide → all outputs 0 immediately (asynchronous). After release, no `result_ready` appears, and a fresh multiply completes normally.
